// File: rtl/lsu_pkg.sv
// Shared constants for the AHB-Lite load/store unit: bus encodings, funct3 fields, FSM states.
package lsu_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  localparam int F3_SIZE_LSB = 0;
  localparam int F3_SIZE_MSB = 1;
  localparam int F3_UNSIGNED = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/lsu_lane.sv
// Combinational lane steering: store-data replication across all byte lanes and
// load-data extraction with zero/sign extension.
module lsu_lane
  import lsu_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int OFF_W = $clog2(XLEN / 8)
) (
  input  logic [1:0]       size,
  input  logic             is_unsigned,
  input  logic [OFF_W-1:0] offset,
  input  logic [XLEN-1:0]  value,
  input  logic [XLEN-1:0]  rdata,
  output logic [XLEN-1:0]  wdata,
  output logic [XLEN-1:0]  rdata_ext
);

  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] mask;
  logic            sign;

  always_comb begin
    wdata = value;
    case (size)
      SIZE_B:  wdata = {(XLEN / 8){value[7:0]}};
      SIZE_H:  wdata = {(XLEN / 16){value[15:0]}};
      SIZE_W:  wdata = {(XLEN / 32){value[31:0]}};
      default: wdata = value;
    endcase
  end

  // Mask-based extension avoids zero-width replications when the access fills XLEN.
  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    mask    = '1;
    sign    = 1'b0;
    case (size)
      SIZE_B: begin
        mask = XLEN'(8'hFF);
        sign = shifted[7];
      end
      SIZE_H: begin
        mask = XLEN'(16'hFFFF);
        sign = shifted[15];
      end
      SIZE_W: begin
        mask = XLEN'(32'hFFFF_FFFF);
        sign = shifted[31];
      end
      default: begin
        mask = '1;
        sign = 1'b0;
      end
    endcase
    rdata_ext = (shifted & mask) | ((sign && !is_unsigned) ? ~mask : '0);
  end

endmodule

// File: rtl/lsu_ahb.sv
// Load/store stage driving an AHB-Lite master with split address/data phases.
// Optional LSU_MISALIGN_TRAP_EN: trap misaligned accesses instead of force-aligning them.
module lsu_ahb
  import lsu_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              EN,
  input  logic              LOAD,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] address,
  input  logic [XLEN-1:0]   value,
  input  logic [XLEN-1:0]   alu_res,
  input  logic [4:0]        rd_i,
  input  logic              write_back,
  input  logic [XLEN-1:0]   HRDATA,
  input  logic              HREADY,
  input  logic              HRESP,
  output logic [ADDR_W-1:0] HADDR,
  output logic [XLEN-1:0]   HWDATA,
  output logic              HWRITE,
  output logic [1:0]        HTRANS,
  output logic [2:0]        HSIZE,
  output logic [XLEN-1:0]   res,
  output logic [4:0]        rd_o,
  output logic              mem_write_back_en,
  output logic              stall,
  output logic              misalign_exc,
  output logic              bus_err
);

  localparam int OFF_W = $clog2(XLEN / 8);

  lsu_state_e        state;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic              req_load;
  logic              req_wb;
  logic [4:0]        req_rd;
  logic [OFF_W-1:0]  req_off;
  logic [XLEN-1:0]   req_value;

  logic [1:0]        in_size;
  logic [1:0]        eff_size;
  logic              illegal_size;
  logic              misaligned;
  logic              trap;
  logic [ADDR_W-1:0] align_mask;
  logic [ADDR_W-1:0] eff_addr;
  logic [XLEN-1:0]   lane_wdata;
  logic [XLEN-1:0]   lane_rdata;

  assign in_size = funct3[F3_SIZE_MSB:F3_SIZE_LSB];

  // Doubleword on a 32-bit datapath is demoted to a word when not trapping.
  always_comb begin
    illegal_size = (XLEN == 32) && (in_size == SIZE_D);
    eff_size     = illegal_size ? SIZE_W : in_size;
    align_mask   = (ADDR_W'(1) << eff_size) - ADDR_W'(1);
    misaligned   = illegal_size || ((address & align_mask) != '0);
    eff_addr     = address & ~align_mask;
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = misaligned;
`else
  assign trap = 1'b0;
`endif

  assign stall = (state != ST_IDLE);

  lsu_lane #(.XLEN(XLEN), .OFF_W(OFF_W)) u_lane (
    .size        (req_size),
    .is_unsigned (req_unsigned),
    .offset      (req_off),
    .value       (req_value),
    .rdata       (HRDATA),
    .wdata       (lane_wdata),
    .rdata_ext   (lane_rdata)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state             <= ST_IDLE;
      req_size          <= '0;
      req_unsigned      <= 1'b0;
      req_load          <= 1'b0;
      req_wb            <= 1'b0;
      req_rd            <= '0;
      req_off           <= '0;
      req_value         <= '0;
      HADDR             <= '0;
      HWDATA            <= '0;
      HWRITE            <= 1'b0;
      HTRANS            <= HTRANS_IDLE;
      HSIZE             <= '0;
      res               <= '0;
      rd_o              <= '0;
      mem_write_back_en <= 1'b0;
      misalign_exc      <= 1'b0;
      bus_err           <= 1'b0;
    end else begin
      misalign_exc <= 1'b0;
      bus_err      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!EN) begin
            res               <= alu_res;
            rd_o              <= rd_i;
            mem_write_back_en <= write_back;
          end else if (trap) begin
            misalign_exc      <= 1'b1;
            mem_write_back_en <= 1'b0;
          end else begin
            req_size          <= eff_size;
            req_unsigned      <= funct3[F3_UNSIGNED];
            req_load          <= LOAD;
            req_wb            <= write_back;
            req_rd            <= rd_i;
            req_off           <= eff_addr[OFF_W-1:0];
            req_value         <= value;
            HADDR             <= eff_addr;
            HTRANS            <= HTRANS_NONSEQ;
            HWRITE            <= ~LOAD;
            HSIZE             <= {1'b0, eff_size};
            mem_write_back_en <= 1'b0;
            state             <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (HREADY) begin
            HTRANS <= HTRANS_IDLE;
            if (!req_load) HWDATA <= lane_wdata;
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (HREADY) begin
            if (HRESP) begin
              bus_err           <= 1'b1;
              mem_write_back_en <= 1'b0;
            end else begin
              if (req_load) res <= lane_rdata;
              mem_write_back_en <= req_wb & req_load;
              rd_o              <= req_rd;
            end
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ahb.sv
// Scoreboard bench for lsu_ahb: expected results are queued when a request is
// driven and popped when the unit finishes it. Honours LSU_MISALIGN_TRAP_EN.
module tb_lsu_ahb;

  localparam int XLEN   = 64;
  localparam int ADDR_W = 64;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic              CLK;
  logic              RST_N;
  logic              EN;
  logic              LOAD;
  logic [2:0]        funct3;
  logic [ADDR_W-1:0] address;
  logic [XLEN-1:0]   value;
  logic [XLEN-1:0]   alu_res;
  logic [4:0]        rd_i;
  logic              write_back;
  logic [XLEN-1:0]   HRDATA;
  logic              HREADY;
  logic              HRESP;
  logic [ADDR_W-1:0] HADDR;
  logic [XLEN-1:0]   HWDATA;
  logic              HWRITE;
  logic [1:0]        HTRANS;
  logic [2:0]        HSIZE;
  logic [XLEN-1:0]   res;
  logic [4:0]        rd_o;
  logic              mem_write_back_en;
  logic              stall;
  logic              misalign_exc;
  logic              bus_err;

  lsu_ahb #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
    .CLK               (CLK),
    .RST_N             (RST_N),
    .EN                (EN),
    .LOAD              (LOAD),
    .funct3            (funct3),
    .address           (address),
    .value             (value),
    .alu_res           (alu_res),
    .rd_i              (rd_i),
    .write_back        (write_back),
    .HRDATA            (HRDATA),
    .HREADY            (HREADY),
    .HRESP             (HRESP),
    .HADDR             (HADDR),
    .HWDATA            (HWDATA),
    .HWRITE            (HWRITE),
    .HTRANS            (HTRANS),
    .HSIZE             (HSIZE),
    .res               (res),
    .rd_o              (rd_o),
    .mem_write_back_en (mem_write_back_en),
    .stall             (stall),
    .misalign_exc      (misalign_exc),
    .bus_err           (bus_err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    string       tag;
    logic [63:0] haddr;
    logic [2:0]  hsize;
    logic        hwrite;
    logic [63:0] hwdata;
    logic [63:0] res;
    logic [4:0]  rd;
    logic        wbe;
    logic        berr;
    logic        exc;
    int          stalls;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  // Byte-by-byte reference for load extraction.
  function automatic logic [63:0] model_load(logic [63:0] rdata, logic [63:0] addr, logic [2:0] f3);
    int nbytes = 1 << f3[1:0];
    int base = int'(addr[2:0]);
    logic [63:0] r = '0;
    for (int b = 0; b < 8; b++)
      if (b < nbytes) r[b*8 +: 8] = rdata[(base + b)*8 +: 8];
    if (!f3[2] && r[nbytes*8 - 1])
      for (int b = 0; b < 8; b++)
        if (b >= nbytes) r[b*8 +: 8] = 8'hFF;
    return r;
  endfunction

  function automatic logic [63:0] model_store(logic [63:0] val, int nbytes);
    logic [63:0] w = '0;
    for (int b = 0; b < 8; b++) w[b*8 +: 8] = val[(b % nbytes)*8 +: 8];
    return w;
  endfunction

  task automatic nonMem(input logic [63:0] alu, input logic [4:0] rd, input logic wb);
    EN = 1'b0; alu_res = alu; rd_i = rd; write_back = wb;
    @(negedge CLK);
    checkOutput("nonmem res", res, alu);
    checkOutput("nonmem rd_o", 64'(rd_o), 64'(rd));
    checkOutput("nonmem wbe", 64'(mem_write_back_en), 64'(wb));
    checkOutput("nonmem stall", 64'(stall), 64'd0);
  endtask

  task automatic applyStimulus(input string tag, input logic load, input logic [2:0] f3,
                               input logic [63:0] addr, input logic [63:0] val, input logic [4:0] rd,
                               input logic wb, input logic [63:0] rdata, input int aw, input int dw,
                               input logic resp);
    exp_t e;
    int nbytes;
    int stalls;
    int budget;
    logic mis;
    nbytes   = 1 << f3[1:0];
    mis      = (addr & 64'(nbytes - 1)) != 64'd0;
    e.tag    = tag;
    e.haddr  = addr & ~64'(nbytes - 1);
    e.hsize  = {1'b0, f3[1:0]};
    e.hwrite = ~load;
    e.hwdata = model_store(val, nbytes);
    e.res    = model_load(rdata, e.haddr, f3);
    e.rd     = rd;
    e.wbe    = resp ? 1'b0 : (wb & load);
    e.berr   = resp;
    e.exc    = TRAP && mis;
    e.stalls = 2 + aw + dw;
    sb.push_back(e);

    EN = 1'b1; LOAD = load; funct3 = f3; address = addr; value = val;
    rd_i = rd; write_back = wb; alu_res = {$urandom, $urandom};
    HREADY = 1'b1; HRESP = 1'b0;
    @(negedge CLK);

    if (e.exc) begin
      e = sb.pop_front();
      checkOutput({tag, " exc"}, 64'(misalign_exc), 64'd1);
      checkOutput({tag, " htrans"}, 64'(HTRANS), 64'd0);
      checkOutput({tag, " stall"}, 64'(stall), 64'd0);
      checkOutput({tag, " wbe"}, 64'(mem_write_back_en), 64'd0);
      EN = 1'b0; write_back = 1'b0;
      @(negedge CLK);
      checkOutput({tag, " exc pulse"}, 64'(misalign_exc), 64'd0);
      return;
    end

    checkOutput({tag, " htrans nonseq"}, 64'(HTRANS), 64'd2);
    checkOutput({tag, " haddr"}, HADDR, sb[$].haddr);
    checkOutput({tag, " hsize"}, 64'(HSIZE), 64'(sb[$].hsize));
    checkOutput({tag, " hwrite"}, 64'(HWRITE), 64'(sb[$].hwrite));
    stalls = int'(stall);
    repeat (aw) begin
      HREADY = 1'b0;
      @(negedge CLK);
      stalls += int'(stall);
    end
    HREADY = 1'b1;
    @(negedge CLK);
    stalls += int'(stall);
    checkOutput({tag, " htrans idle"}, 64'(HTRANS), 64'd0);
    if (!load) checkOutput({tag, " hwdata"}, HWDATA, sb[$].hwdata);
    repeat (dw) begin
      HREADY = 1'b0;
      @(negedge CLK);
      stalls += int'(stall);
    end
    HREADY = 1'b1; HRDATA = rdata; HRESP = resp;
    budget = 0;
    do begin
      @(negedge CLK);
      stalls += int'(stall);
      budget++;
    end while (stall && budget < 16);

    e = sb.pop_front();
    checkOutput({e.tag, " done"}, 64'(stall), 64'd0);
    checkOutput({e.tag, " stall cycles"}, 64'(stalls), 64'(e.stalls));
    checkOutput({e.tag, " wbe"}, 64'(mem_write_back_en), 64'(e.wbe));
    checkOutput({e.tag, " bus_err"}, 64'(bus_err), 64'(e.berr));
    checkOutput({e.tag, " exc"}, 64'(misalign_exc), 64'd0);
    if (!resp) checkOutput({e.tag, " rd_o"}, 64'(rd_o), 64'(e.rd));
    if (load && !resp) checkOutput({e.tag, " res"}, res, e.res);

    HRESP = 1'b0; EN = 1'b0; write_back = 1'b0;
    @(negedge CLK);
    checkOutput({e.tag, " bus_err pulse"}, 64'(bus_err), 64'd0);
    checkOutput({e.tag, " idle wbe"}, 64'(mem_write_back_en), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    RST_N = 1'b0; EN = 1'b0; LOAD = 1'b0; funct3 = '0; address = '0; value = '0;
    alu_res = '0; rd_i = '0; write_back = 1'b0; HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
    repeat (2) @(negedge CLK);
    checkOutput("reset htrans", 64'(HTRANS), 64'd0);
    checkOutput("reset stall", 64'(stall), 64'd0);
    checkOutput("reset res", res, 64'd0);
    checkOutput("reset hsize", 64'(HSIZE), 64'd0);
    checkOutput("reset wbe", 64'(mem_write_back_en), 64'd0);
    RST_N = 1'b1;

    nonMem(64'h1234, 5'd5, 1'b1);
    nonMem(64'hDEAD_BEEF_0000_0001, 5'd31, 1'b0);

    applyStimulus("LB", 1'b1, 3'b000, 64'h1003, 64'd0, 5'd7, 1'b1, 64'h0000_0000_8000_0000, 0, 0, 1'b0);
    applyStimulus("LBU", 1'b1, 3'b100, 64'h1003, 64'd0, 5'd8, 1'b1, 64'h0000_0000_8000_0000, 0, 0, 1'b0);
    applyStimulus("SH", 1'b0, 3'b001, 64'h2002, 64'hBEEF, 5'd9, 1'b0, 64'd0, 0, 3, 1'b0);
    applyStimulus("LW misaligned", 1'b1, 3'b010, 64'h1002, 64'd0, 5'd10, 1'b1, 64'h1122_3344_A5B6_C7D8, 0, 0, 1'b0);
    applyStimulus("LD buserr", 1'b1, 3'b011, 64'h4000, 64'd0, 5'd11, 1'b1, 64'h0123_4567_89AB_CDEF, 0, 0, 1'b1);
    applyStimulus("LH addrwait", 1'b1, 3'b001, 64'h5006, 64'd0, 5'd12, 1'b1, 64'h8001_2345_6789_ABCD, 2, 1, 1'b0);
    applyStimulus("LWU", 1'b1, 3'b110, 64'h6004, 64'd0, 5'd13, 1'b1, 64'hF000_0001_7FFF_FFFF, 0, 0, 1'b0);
    applyStimulus("SB", 1'b0, 3'b000, 64'h7005, 64'h5A, 5'd14, 1'b1, 64'd0, 1, 0, 1'b0);
    applyStimulus("SD", 1'b0, 3'b011, 64'h7008, 64'hCAFE_F00D_1234_5678, 5'd15, 1'b0, 64'd0, 0, 2, 1'b0);
    applyStimulus("LD", 1'b1, 3'b011, 64'h7010, 64'd0, 5'd16, 1'b0, 64'hFEDC_BA98_7654_3210, 0, 0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      logic [2:0] f3;
      logic [63:0] a;
      f3 = 3'($urandom_range(0, 7));
      if (f3 == 3'b111) f3 = 3'b011;
      a = 64'h8000 + 64'($urandom_range(0, 7)) & ~64'((1 << f3[1:0]) - 1);
      applyStimulus("rand load", 1'b1, f3, a, 64'd0, 5'($urandom_range(1, 31)), 1'b1,
                    {$urandom, $urandom}, $urandom_range(0, 2), $urandom_range(0, 2), 1'b0);
    end

    nonMem(64'h0000_00AB_CDEF_0123, 5'd3, 1'b1);

    // Abort a transfer in its data phase with an asynchronous reset.
    EN = 1'b1; LOAD = 1'b0; funct3 = 3'b011; address = 64'h9000; value = 64'h1111_2222_3333_4444;
    rd_i = 5'd20; write_back = 1'b1; HREADY = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    HREADY = 1'b0;
    @(negedge CLK);
    checkOutput("pre-reset stall", 64'(stall), 64'd1);
    RST_N = 1'b0;
    #1;
    checkOutput("abort htrans", 64'(HTRANS), 64'd0);
    checkOutput("abort stall", 64'(stall), 64'd0);
    checkOutput("abort haddr", HADDR, 64'd0);
    checkOutput("abort hwdata", HWDATA, 64'd0);
    checkOutput("abort hwrite", 64'(HWRITE), 64'd0);
    checkOutput("abort res", res, 64'd0);
    checkOutput("abort rd_o", 64'(rd_o), 64'd0);
    EN = 1'b0; HREADY = 1'b1;
    @(negedge CLK);
    RST_N = 1'b1;
    nonMem(64'h55, 5'd1, 1'b1);

    checkOutput("scoreboard empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_ahb.md
# lsu_ahb

Parametrised load/store stage sitting between execute and write-back in the core pipeline, replacing the single-cycle memory access stage. It drives an AHB-Lite master port with a proper address/data phase split, honours HREADY wait states by stalling the pipeline, and supports byte/half/word/double accesses with lane steering and sign extension. Non-memory instructions pass their ALU result through with one cycle of latency.

## Interface
- XLEN, 64, datapath and HRDATA/HWDATA width; 32 or 64
- ADDR_W, 64, HADDR width
- CLK  in  1  clock; all state on rising edge
- RST_N  in  1  asynchronous, active-low reset
- EN  in  1  memory instruction valid this cycle
- LOAD  in  1  1 = load, 0 = store
- funct3  in  3  RISC-V size/sign code: [1:0] size (0 B, 1 H, 2 W, 3 D), [2] unsigned
- address  in  ADDR_W  effective address
- value  in  XLEN  store data (right-justified)
- alu_res  in  XLEN  result for non-memory instructions
- rd_i  in  5  destination register
- write_back  in  1  instruction writes rd
- HRDATA  in  XLEN  bus read data
- HREADY  in  1  bus transfer complete
- HRESP  in  1  bus error response
- HADDR  out  ADDR_W  bus address
- HWDATA  out  XLEN  bus write data
- HWRITE  out  1  bus direction
- HTRANS  out  2  0 IDLE, 2 NONSEQ
- HSIZE  out  3  transfer size
- res  out  XLEN  result to write-back
- rd_o  out  5  destination register to write-back
- mem_write_back_en  out  1  write-back strobe
- stall  out  1  upstream must hold inputs
- misalign_exc  out  1  one-cycle misaligned/illegal access pulse
- bus_err  out  1  one-cycle bus error pulse

## Operation
- FSM states: IDLE, ADDR, DATA.
- IDLE, EN=0: res<=alu_res, rd_o<=rd_i, mem_write_back_en<=write_back.
- IDLE, EN=1, aligned: latch request; HADDR<=address, HTRANS<=NONSEQ, HWRITE<=~LOAD, HSIZE<={0,funct3[1:0]}; mem_write_back_en<=0; -> ADDR.
- ADDR: hold. On HREADY: HTRANS<=IDLE; store: HWDATA<=value low bytes replicated across all lanes (B x8, H x4, W x2, D x1 for XLEN=64); -> DATA.
- DATA: hold while HREADY=0. On HREADY & ~HRESP: load: res<=HRDATA>>(addr[2:0]*8) truncated to size, sign-extended unless funct3[2]; mem_write_back_en<=write_back&LOAD; rd_o<=latched rd; -> IDLE. On HREADY & HRESP: bus_err<=1, mem_write_back_en<=0, -> IDLE.
- Misaligned (address not a multiple of 1<<size) or size 3 with XLEN=32: no bus transfer; behaviour per Configuration.
- stall = (state != IDLE); decoded from registered state only.

## Timing
- Reset: state IDLE; all outputs 0 (HTRANS IDLE, HSIZE 0, stall 0); takes effect immediately, aborting any transfer mid-phase.
- Non-memory latency: 1 cycle.
- Memory op, zero wait states: accepted edge 0, address phase edge 0–1, data phase edge 1–2, result valid after edge 2; stall high 2 cycles.
- Each HREADY=0 cycle in ADDR or DATA adds one cycle of stall.
- EN ignored while stall=1; upstream holds all inputs.
- misalign_exc and bus_err are single-cycle pulses, never simultaneous with mem_write_back_en.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: misaligned/illegal access raises misalign_exc for one cycle, no write-back, FSM stays IDLE.
- Undefined: misalign_exc tied 0; address low bits are cleared to the size alignment and the access proceeds normally.

## Structure
- Shared package lsu_pkg: HTRANS/HSIZE constants, funct3 size/unsigned field positions, FSM state encoding.
- One sub-module lsu_lane: combinational store-lane replication and load extract/sign-extend, parametrised on XLEN.

## Test plan
- EN=0, alu_res=0x1234, rd_i=5, write_back=1 -> next cycle res=0x1234, rd_o=5, mem_write_back_en=1.
- LB at 0x1003, HRDATA=0x00000000_80000000, HREADY=1 -> stall 2 cycles, HSIZE=0, res=0xFFFF_FFFF_FFFF_FF80; LBU -> 0x80.
- SH value=0xBEEF at 0x2002, HREADY low 3 cycles in DATA -> HWDATA=0xBEEFBEEF_BEEFBEEF, HWRITE=1, stall 5 cycles, mem_write_back_en=0.
- LW at 0x1002 with LSU_MISALIGN_TRAP_EN -> misalign_exc pulse, HTRANS stays 0; without macro -> HADDR=0x1000.
- LD with HRESP=1, HREADY=1 in DATA -> bus_err pulse, mem_write_back_en=0, back to IDLE.
- RST_N low during DATA -> HTRANS=0, stall=0, all outputs 0 at once.
